// File: rtl/airhockey_pkg.sv
// Shared types and constants for the air hockey match controller.
package airhockey_pkg;

    // Match phases; the encoding is visible on the state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GOAL  = 3'd3,
        ST_OVER  = 3'd4
    } phase_e;

    // NES pad bit positions.
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;

    localparam logic [3:0] SCORE_MAX = 4'd15;

    // Score increment that sticks at 15.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == SCORE_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Signal bundle between the pad/goal sources and the match controller.
interface match_sequencer_if;
    logic        vSyncStart;
    logic        start;
    logic        goalLeft;
    logic        goalRight;
    logic [7:0]  button2;
    logic [15:0] puckY;
    logic [15:0] paddle2Y;
    logic        paddleRun;
    logic        puckRun;
    logic        puckReset;
    logic        serveToLeft;
    logic [3:0]  scoreLeft;
    logic [3:0]  scoreRight;
    logic [2:0]  state;
    logic [7:0]  button2Out;

    modport master (
        output vSyncStart, start, goalLeft, goalRight, button2, puckY, paddle2Y,
        input  paddleRun, puckRun, puckReset, serveToLeft, scoreLeft, scoreRight,
               state, button2Out
    );

    modport slave (
        input  vSyncStart, start, goalLeft, goalRight, button2, puckY, paddle2Y,
        output paddleRun, puckRun, puckReset, serveToLeft, scoreLeft, scoreRight,
               state, button2Out
    );
endinterface

// File: rtl/autopilot_tracker.sv
// Drives the right paddle toward the puck once player 2 has been idle
// long enough; any up/down press hands control straight back.
module autopilot_tracker
    import airhockey_pkg::*;
#(
    parameter int IDLE_FRAMES   = 600,
    parameter int PADDLE_HEIGHT = 48,
    parameter int DEADBAND      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [7:0]  btn_in,
    input  logic [15:0] puck_y,
    input  logic [15:0] paddle_y,
    output logic [7:0]  btn_out
);
    localparam logic [9:0]  IDLE_MAX = 10'(IDLE_FRAMES);
    localparam logic [16:0] HALF_H   = 17'(PADDLE_HEIGHT / 2);
    localparam logic [16:0] DB       = 17'(DEADBAND);

    logic [9:0]  idle_q, idle_d;
    logic        pressed;
    logic [16:0] centre, puck17;
    logic        want_up, want_dn;

    assign pressed = btn_in[BTN_UP] | btn_in[BTN_DOWN];

    // 17-bit compare so neither the centre sum nor the deadband wraps.
    assign centre  = {1'b0, paddle_y} + HALF_H;
    assign puck17  = {1'b0, puck_y};
    assign want_up = (puck17 + DB) < centre;
    assign want_dn = puck17 > (centre + DB);

    // Idle frame counter: cleared by any press, saturates at the takeover point.
    always_comb begin
        idle_d = idle_q;
        if (pressed)
            idle_d = '0;
        else if (vsync && idle_q < IDLE_MAX)
            idle_d = idle_q + 10'd1;
    end

    // Idle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end

    // Substitute up/down only while idle and nobody is pressing right now.
    always_comb begin
        btn_out = btn_in;
        if (idle_q == IDLE_MAX && !pressed) begin
            btn_out[BTN_UP]   = want_up;
            btn_out[BTN_DOWN] = want_dn;
        end
    end
endmodule

// File: rtl/match_sequencer.sv
// Match phase controller for air hockey: idle, serve, play, goal pause,
// game over. Gates paddle/puck motion, keeps scores, requests re-serves.
// Optional feature: define AIRHOCKEY_AUTOPILOT_EN to let an autopilot
// drive the right paddle when player 2 stops pressing up/down.
module match_sequencer
    import airhockey_pkg::*;
#(
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int PAUSE_FRAMES  = 120,
    parameter int IDLE_FRAMES   = 600,
    parameter int PADDLE_HEIGHT = 48,
    parameter int DEADBAND      = 4
) (
    input  logic              pixelClock,
    input  logic              reset,
    match_sequencer_if.slave  bus
);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    phase_e     state_q, state_d;
    logic [7:0] fc_q, fc_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       serve_left_q, serve_left_d;
    logic       puck_reset_q, puck_reset_d;
    logic       paddle_run_q, paddle_run_d;
    logic       puck_run_q, puck_run_d;
    logic       start_q, start_d;
    logic       start_rise;

    assign start_d    = bus.start;
    assign start_rise = bus.start & ~start_q;

    // Phase transitions, scoring and per-frame counting.
    always_comb begin
        state_d      = state_q;
        fc_d         = bus.vSyncStart ? fc_q + 8'd1 : fc_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        serve_left_d = serve_left_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    score_l_d    = '0;
                    score_r_d    = '0;
                    serve_left_d = 1'b0;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.vSyncStart && fc_q == SERVE_LAST)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Left goal has priority when both fire together.
                if (bus.goalLeft) begin
                    score_r_d    = sat_inc(score_r_q);
                    serve_left_d = 1'b1;
                    state_d      = ST_GOAL;
                end else if (bus.goalRight) begin
                    score_l_d    = sat_inc(score_l_q);
                    serve_left_d = 1'b0;
                    state_d      = ST_GOAL;
                end
            end
            ST_GOAL: begin
                if (bus.vSyncStart && fc_q == PAUSE_LAST)
                    state_d = (score_l_q == WIN || score_r_q == WIN) ? ST_OVER : ST_SERVE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Every phase starts counting frames from zero.
        if (state_d != state_q)
            fc_d = '0;
    end

    // Registered outputs are precomputed from the next phase.
    always_comb begin
        puck_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        paddle_run_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
        puck_run_d   = (state_d == ST_PLAY);
    end

    // Controller state registers.
    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fc_q         <= '0;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_left_q <= 1'b0;
            puck_reset_q <= 1'b0;
            paddle_run_q <= 1'b0;
            puck_run_q   <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fc_q         <= fc_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_left_q <= serve_left_d;
            puck_reset_q <= puck_reset_d;
            paddle_run_q <= paddle_run_d;
            puck_run_q   <= puck_run_d;
            start_q      <= start_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.scoreLeft   = score_l_q;
    assign bus.scoreRight  = score_r_q;
    assign bus.serveToLeft = serve_left_q;
    assign bus.puckReset   = puck_reset_q;
    assign bus.paddleRun   = paddle_run_q;
    assign bus.puckRun     = puck_run_q;

`ifdef AIRHOCKEY_AUTOPILOT_EN
    autopilot_tracker #(
        .IDLE_FRAMES  (IDLE_FRAMES),
        .PADDLE_HEIGHT(PADDLE_HEIGHT),
        .DEADBAND     (DEADBAND)
    ) u_autopilot (
        .clk     (pixelClock),
        .rst     (reset),
        .vsync   (bus.vSyncStart),
        .btn_in  (bus.button2),
        .puck_y  (bus.puckY),
        .paddle_y(bus.paddle2Y),
        .btn_out (bus.button2Out)
    );
`else
    // Positions only matter to the autopilot.
    logic unused_pos;
    assign unused_pos     = ^{bus.puckY, bus.paddle2Y};
    assign bus.button2Out = bus.button2;
`endif
endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed match scenarios with literal
// expectations plus a randomized run against a phase/countdown model.
module tb_match_sequencer;
    localparam int WIN = 7, SERVE_N = 60, PAUSE_N = 120, IDLE_N = 600, PH = 48, DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    match_sequencer_if bus();

    match_sequencer dut (.pixelClock(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase number, frames still to wait, scores, serve side.
    int m_phase, m_left, m_sl, m_sr, m_idle;
    bit m_stl, m_pr, prev_start, rise;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0; m_left = 0; m_sl = 0; m_sr = 0; m_idle = 0;
            m_stl = 0; m_pr = 0; prev_start = 0;
        end else begin
            rise = bus.start && !prev_start;
            prev_start = bus.start;
            m_pr = 0;
            if (bus.button2[4] || bus.button2[5]) m_idle = 0;
            else if (bus.vSyncStart && m_idle < IDLE_N) m_idle++;
            case (m_phase)
                0, 4: if (rise) begin
                    m_sl = 0; m_sr = 0; m_stl = 0;
                    m_phase = 1; m_pr = 1; m_left = SERVE_N;
                end
                1: if (bus.vSyncStart) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (bus.goalLeft) begin
                    m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_stl = 1;
                    m_phase = 3; m_left = PAUSE_N;
                end else if (bus.goalRight) begin
                    m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_stl = 0;
                    m_phase = 3; m_left = PAUSE_N;
                end
                3: if (bus.vSyncStart) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_sl == WIN || m_sr == WIN) m_phase = 4;
                        else begin m_phase = 1; m_pr = 1; m_left = SERVE_N; end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    function automatic logic [7:0] exp_b2();
        logic [7:0] b;
`ifdef AIRHOCKEY_AUTOPILOT_EN
        int c;
`endif
        b = bus.button2;
`ifdef AIRHOCKEY_AUTOPILOT_EN
        c = int'(bus.paddle2Y) + PH / 2;
        if (m_idle == IDLE_N && !b[4] && !b[5]) begin
            b[4] = int'(bus.puckY) < c - DB;
            b[5] = int'(bus.puckY) > c + DB;
        end
`endif
        return b;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("state", 32'(bus.state), 32'(m_phase));
            chk("scoreLeft", 32'(bus.scoreLeft), 32'(m_sl));
            chk("scoreRight", 32'(bus.scoreRight), 32'(m_sr));
            chk("serveToLeft", 32'(bus.serveToLeft), 32'(m_stl));
            chk("puckReset", 32'(bus.puckReset), 32'(m_pr));
            chk("paddleRun", 32'(bus.paddleRun), 32'(m_phase == 1 || m_phase == 2));
            chk("puckRun", 32'(bus.puckRun), 32'(m_phase == 2));
            chk("button2Out", 32'(bus.button2Out), 32'(exp_b2()));
        end
    end

    task automatic tick(input bit vs, input bit gl, input bit gr);
        bus.vSyncStart = vs; bus.goalLeft = gl; bus.goalRight = gr;
        @(posedge clk); #1;
        bus.vSyncStart = 0; bus.goalLeft = 0; bus.goalRight = 0;
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        end
    endtask

    initial begin
        bus.vSyncStart = 0; bus.start = 0; bus.goalLeft = 0; bus.goalRight = 0;
        bus.button2 = 8'h5A; bus.puckY = 16'd100; bus.paddle2Y = 16'd200;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_scoreLeft", 32'(bus.scoreLeft), 0);
        chk("rst_scoreRight", 32'(bus.scoreRight), 0);
        chk("rst_runs", 32'({bus.paddleRun, bus.puckRun, bus.puckReset, bus.serveToLeft}), 0);
        chk("rst_button2Out", 32'(bus.button2Out), 32'h5A);
        bus.button2 = 0;
        rst = 0;
        tick(0, 0, 0); tick(0, 0, 0);

        // Start edge launches a serve.
        bus.start = 1; tick(0, 0, 0);
        chk("start_state", 32'(bus.state), 1);
        chk("start_puckReset", 32'(bus.puckReset), 1);
        chk("serve_puckRun", 32'(bus.puckRun), 0);
        tick(0, 0, 0);
        chk("puckReset_single", 32'(bus.puckReset), 0);
        bus.start = 0;
        frames(59);
        chk("serve_hold", 32'(bus.state), 1);
        tick(1, 0, 0);
        chk("play_state", 32'(bus.state), 2);
        chk("play_puckRun", 32'(bus.puckRun), 1);

        // Simultaneous goals: left wins.
        tick(0, 1, 1);
        chk("both_scoreRight", 32'(bus.scoreRight), 1);
        chk("both_scoreLeft", 32'(bus.scoreLeft), 0);
        chk("both_state", 32'(bus.state), 3);
        chk("both_serveToLeft", 32'(bus.serveToLeft), 1);
        frames(119);
        chk("pause_hold", 32'(bus.state), 3);
        tick(1, 0, 0);
        chk("reserve_state", 32'(bus.state), 1);
        chk("reserve_puckReset", 32'(bus.puckReset), 1);
        frames(SERVE_N);
        tick(0, 0, 1);
        chk("goalR_scoreLeft", 32'(bus.scoreLeft), 1);
        chk("goalR_state", 32'(bus.state), 3);
        chk("goalR_serveToLeft", 32'(bus.serveToLeft), 0);

        // Fresh match to 7-0.
        rst = 1; tick(0, 0, 0); rst = 0;
        bus.start = 1; tick(0, 0, 0); bus.start = 0;
        for (int g = 0; g < WIN; g++) begin
            frames(SERVE_N); tick(0, 0, 1); frames(PAUSE_N);
        end
        chk("over_state", 32'(bus.state), 4);
        chk("over_scoreLeft", 32'(bus.scoreLeft), 7);
        chk("over_runs", 32'({bus.paddleRun, bus.puckRun}), 0);
        tick(0, 0, 1);
        chk("over_goal_ignored", 32'(bus.scoreLeft), 7);
        bus.start = 1; tick(0, 0, 0); bus.start = 0;
        chk("restart_scores", 32'({bus.scoreLeft, bus.scoreRight}), 0);
        chk("restart_state", 32'(bus.state), 1);

        // Asynchronous reset in the middle of a goal pause.
        frames(SERVE_N); tick(0, 1, 0); frames(10);
        chk("pre_rst_state", 32'(bus.state), 3);
        rst = 1; #1;
        chk("async_rst_state", 32'(bus.state), 0);
        chk("async_rst_scoreRight", 32'(bus.scoreRight), 0);
        @(posedge clk); #1;
        rst = 0;

`ifdef AIRHOCKEY_AUTOPILOT_EN
        bus.button2 = 0; bus.puckY = 16'd100; bus.paddle2Y = 16'd200;
        frames(IDLE_N);
        chk("ap_up", 32'(bus.button2Out[4]), 1);
        chk("ap_dn", 32'(bus.button2Out[5]), 0);
        bus.button2 = 8'h20; #1;
        chk("ap_press_dn", 32'(bus.button2Out[5]), 1);
        chk("ap_press_up", 32'(bus.button2Out[4]), 0);
        bus.button2 = 0;
        tick(0, 0, 0);
`endif

        // Randomized traffic checked every cycle by the compare process.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(19) == 0) bus.start = ~bus.start;
            bus.button2  = 8'($urandom);
            bus.puckY    = 16'($urandom);
            bus.paddle2Y = 16'($urandom);
            tick($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/match_sequencer.md
# match_sequencer

Frame-level game controller for VGA air hockey. It sequences a match through idle, serve, play, goal-pause and game-over phases. It gates when paddles and puck may move, keeps both scores and requests puck re-serves. It sits between the NES pad decoders and the paddle/puck movers, and its `paddleRun`/`puckRun` qualify their per-frame `vSyncStart` updates.

## Interface
Parameters:
- `WIN_SCORE`, 7: score that ends the match; must be 1..15.
- `SERVE_FRAMES`, 60: frames the puck is held before play; must be 1..255.
- `PAUSE_FRAMES`, 120: frames frozen after a goal; must be 1..255.
- `IDLE_FRAMES`, 600: autopilot takeover delay; must be 1..1023.
- `PADDLE_HEIGHT`, 48: right paddle height in pixels.
- `DEADBAND`, 4: autopilot tolerance in pixels.

Ports:
- `pixelClock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `vSyncStart` in 1: one-cycle pulse per frame.
- `start` in 1: level input (player-1 Start); rising edge acts.
- `goalLeft` in 1: one-cycle pulse; puck entered the left goal.
- `goalRight` in 1: one-cycle pulse; puck entered the right goal.
- `button2` in 8: raw player-2 pad.
- `puckY` in 16: puck top y.
- `paddle2Y` in 16: right paddle top y.
- `paddleRun` out 1: paddles may move.
- `puckRun` out 1: puck may move.
- `puckReset` out 1: one-cycle pulse; re-centre puck.
- `serveToLeft` out 1: serve direction.
- `scoreLeft` out 4: left player score.
- `scoreRight` out 4: right player score.
- `state` out 3: current phase.
- `button2Out` out 8: pad value fed to the right paddle.

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4. One 8-bit frame counter `fc` counts `vSyncStart` pulses and is cleared on every state entry.
- Reset values:
  - state=IDLE.
  - All outputs 0, including both scores.
  - `button2Out` follows `button2` combinationally.
- IDLE or OVER, `start` rising edge (registered `start` vs previous sample):
  - Clear both scores; `serveToLeft`=0.
  - Pulse `puckReset`; go to SERVE.
- SERVE:
  - `paddleRun`=1, `puckRun`=0.
  - On a `vSyncStart` with `fc`==SERVE_FRAMES-1, go to PLAY; otherwise `fc`++ on `vSyncStart`.
- PLAY: `paddleRun`=`puckRun`=1.
  - `goalLeft`: `scoreRight`++, `serveToLeft`=1, go to GOAL.
  - `goalRight`: `scoreLeft`++, `serveToLeft`=0, go to GOAL.
  - Both in the same cycle: `goalLeft` wins and `goalRight` is dropped.
- GOAL:
  - Both run outputs 0.
  - On a `vSyncStart` with `fc`==PAUSE_FRAMES-1: go to OVER if either score equals WIN_SCORE; otherwise go to SERVE with a `puckReset` pulse.
- OVER:
  - Run outputs 0; scores held.
- Events out of phase:
  - Goals outside PLAY are ignored.
  - `start` outside IDLE and OVER is ignored.
- Scores saturate at 15.

## Timing
- All outputs are registered except `button2Out`.
- State and score update on the clock edge after the event cycle.
- `puckReset` is high for exactly the first cycle of the SERVE state.
- SERVE lasts SERVE_FRAMES `vSyncStart` pulses; GOAL lasts PAUSE_FRAMES.
- `reset` asserted mid-match returns to IDLE immediately (asynchronously) with scores 0.

## Configuration
- `AIRHOCKEY_AUTOPILOT_EN` defined:
  - A 10-bit idle counter increments on each `vSyncStart` in which `button2[BTN_UP]` and `button2[BTN_DOWN]` are both 0, saturating at IDLE_FRAMES.
  - Any up/down press clears the counter and takes effect combinationally in the same cycle.
  - At IDLE_FRAMES, `button2Out` up/down bits are replaced (other bits pass through). With centre = `paddle2Y`+PADDLE_HEIGHT/2:
    - UP when `puckY` < centre-DEADBAND.
    - DOWN when `puckY` > centre+DEADBAND.
    - Neither otherwise.
  - Compare at 17 bits, no wrap.
- Not defined: `button2Out` = `button2`; `puckY` and `paddle2Y` are unused.

## Structure
- Package `airhockey_pkg`:
  - State enum (3-bit).
  - `BTN_UP`=4, `BTN_DOWN`=5, `BTN_START`=3.
- Sub-module `autopilot_tracker`: idle counter plus compare logic, instantiated only under the macro.

## Test plan
- Reset then `start` pulse:
  - `puckReset` high for 1 cycle; state=1.
  - After 60 `vSyncStart` pulses: state=2, `puckRun`=1.
- In PLAY, pulse `goalRight`:
  - `scoreLeft`=1, state=3, `serveToLeft`=0.
  - After 120 frames: state=1 with a `puckReset` pulse.
- `goalLeft` and `goalRight` in the same cycle:
  - `scoreRight`=1, `scoreLeft`=0.
- Reach 7-0, then finish the pause:
  - state=4 and run outputs 0.
  - `start` edge: scores 0, state=1.
- Assert `reset` mid-GOAL:
  - state=0 and scores 0 without waiting for a clock edge.
- Macro on, no presses for 600 frames, `puckY`=100, `paddle2Y`=200:
  - `button2Out[4]`=1.
  - Pressing Down gives `button2Out[5]`=1 and `[4]`=0 in the same cycle.
